first_nios2_system_sysid_checker: RTL
=====================================

# first_nios2_system_sysid_checker

Avalon-MM read master that interrogates the system ID peripheral after reset or on software/debug request. It reads word 0 (system ID) and word 1 (build timestamp), compares both against build-time expected values, and reports pass/fail/timeout on sticky status outputs. It sits on the system interconnect beside the Nios II data master and lets board-level logic confirm that the loaded FPGA image matches the expected software build.

## Interface

Parameters:
- EXPECTED_ID, 32'd0, expected value of sysid word 0
- EXPECTED_TIMESTAMP, 32'd1520801304 (0x5AA59618), expected value of sysid word 1
- TIMEOUT_CYCLES, 255, consecutive waitrequest-high cycles tolerated per read (1..65535)

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request a check; sampled only in IDLE
- address  out  1  Avalon word address to sysid slave (0 = ID, 1 = timestamp)
- read  out  1  Avalon read strobe
- readdata  in  32  Avalon read data; valid when read=1 and waitrequest=0
- waitrequest  in  1  slave stall; tie 0 for the zero-wait sysid slave
- busy  out  1  high from the cycle after start is accepted until DONE exits
- done  out  1  one-cycle pulse in the DONE state
- id_ok  out  1  sticky: captured ID equals EXPECTED_ID
- ts_ok  out  1  sticky: captured timestamp equals EXPECTED_TIMESTAMP
- timeout  out  1  sticky: a read stalled TIMEOUT_CYCLES cycles
- id_value  out  32  last captured ID word
- ts_value  out  32  last captured timestamp word

## Operation

- States: IDLE, RD_ID, RD_TS, DONE.
- IDLE: read=0, address=0, busy=0. start=1 -> RD_ID; at the same edge, id_ok, ts_ok, timeout and the wait counter clear to 0. id_value and ts_value hold their old values until overwritten.
- RD_ID: read=1, address=0. waitrequest=0 at edge -> id_value<=readdata, wait counter<=0, go to RD_TS. waitrequest=1 -> counter+1; if counter reaches TIMEOUT_CYCLES-1 while stalled -> timeout<=1, go to DONE.
- RD_TS: read=1, address=1; same rules, capturing into ts_value. On capture -> DONE.
- DONE: read=0, done=1, busy=1; on the entry edge, id_ok<=(id_value==EXPECTED_ID) using the captured value and ts_ok<=(readdata==EXPECTED_TIMESTAMP) at capture. On timeout entry both ok flags stay 0. Always -> IDLE after one cycle.
- Wait counter is 16 bits and saturates, so it cannot wrap. It resets to 0 on every state change.
- start while busy is ignored; it does not queue. start held high re-triggers on each return to IDLE.
- address and read change only on clock edges. read is never asserted outside RD_ID/RD_TS. While waitrequest=1, address and read stay stable (Avalon rule).
- Comparison is a full 32-bit equality; no masking.

## Timing

- Reset (asynchronous assert, synchronous release): state=IDLE, read=0, address=0, busy=0, done=0, id_ok=0, ts_ok=0, timeout=0, id_value=0, ts_value=0, counter=0.
- Zero-wait slave: start sampled at edge N; RD_ID during cycle N+1; RD_TS during N+2; DONE (done=1, flags valid) during N+3; IDLE at N+4. Next start is accepted at edge N+4.
- Each waitrequest-high cycle adds one cycle of latency.
- Timeout: with waitrequest stuck high, DONE is entered TIMEOUT_CYCLES cycles after entering the read state.
- reset_n low mid-transaction: read drops immediately (asynchronously), and all state and flags return to reset values.

## Test plan

- Zero-wait slave returning 0 / 1520801304, one-cycle start pulse -> read high for 2 cycles (address 0 then 1); done at start+3; id_ok=1, ts_ok=1, timeout=0, ts_value=0x5AA59618.
- Slave returns timestamp 0x5AA59619 -> ts_ok=0, id_ok=1, done at start+3, ts_value=0x5AA59619.
- waitrequest high for 3 cycles on each read -> address/read stable while stalled; done at start+9; both ok flags=1.
- waitrequest stuck high with TIMEOUT_CYCLES=4 -> timeout=1 and done after 4 stalled cycles in RD_ID; id_ok=ts_ok=0; read never asserts with address=1.
- start pulsed during RD_TS, then a second check with changed slave data -> the first start is ignored; the second check clears the flags at acceptance and reports the new values.
- reset_n asserted during RD_ID -> read=0 and all outputs at reset values in the same cycle; after release, a start runs a clean check.

Source files
------------

// File: rtl/first_nios2_system_sysid_checker.sv
// first_nios2_system_sysid_checker
//   Avalon-MM read master that reads the sysid peripheral (word 0 = system
//   ID, word 1 = build timestamp) after a start request. It compares both
//   words against build-time constants and reports sticky pass/fail/timeout.
//
// Ports
//   clock, reset_n        system clock, async active-low reset
//   start                 request a check (only honoured in IDLE)
//   address, read         Avalon master command to the sysid slave
//   readdata, waitrequest Avalon slave response
//   busy, done            check in progress / one-cycle completion pulse
//   id_ok, ts_ok          sticky compare results of the last check
//   timeout               sticky: a read stalled for TIMEOUT_CYCLES cycles
//   id_value, ts_value    last captured ID / timestamp words
module first_nios2_system_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1520801304,
   parameter int unsigned TIMEOUT_CYCLES     = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        address,
   output logic        read,
   input  logic [31:0] readdata,
   input  logic        waitrequest,
   output logic        busy,
   output logic        done,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;

   // Last counter value tolerated while stalled; one more stall times out.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state, state_nxt;
   logic [15:0] wait_cnt;
   logic        accept;     // start taken in IDLE
   logic        capture;    // read completes this edge
   logic        stall_out;  // stall limit reached this edge

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      capture   = 1'b0;
      stall_out = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               accept    = 1'b1;
               state_nxt = RD_ID;
            end
         end
         RD_ID, RD_TS: begin
            if (!waitrequest) begin
               capture   = 1'b1;
               state_nxt = (state == RD_ID) ? RD_TS : DONE;
            end else if (wait_cnt == TO_LAST) begin
               stall_out = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Command outputs decode straight from the state register, so they only
   // move on clock edges and drop the moment reset asserts.
   assign read    = (state == RD_ID) || (state == RD_TS);
   assign address = (state == RD_TS);
   assign busy    = (state != IDLE);
   assign done    = (state == DONE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt <= '0;
         id_ok    <= 1'b0;
         ts_ok    <= 1'b0;
         timeout  <= 1'b0;
         id_value <= '0;
         ts_value <= '0;
      end else begin
         if (accept) begin
            id_ok   <= 1'b0;
            ts_ok   <= 1'b0;
            timeout <= 1'b0;
         end

         // Counter restarts on every state change and saturates otherwise.
         if (state_nxt != state)
            wait_cnt <= '0;
         else if (read && waitrequest && (wait_cnt != 16'hFFFF))
            wait_cnt <= wait_cnt + 16'd1;

         if (capture && (state == RD_ID))
            id_value <= readdata;

         // Both flags resolve on the DONE entry edge; ID uses the word
         // already captured, timestamp uses the word on the bus now.
         if (capture && (state == RD_TS)) begin
            ts_value <= readdata;
            ts_ok    <= (readdata == EXPECTED_TIMESTAMP);
            id_ok    <= (id_value == EXPECTED_ID);
         end

         if (stall_out)
            timeout <= 1'b1;
      end
   end

endmodule
